// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states and latched operation codes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERV_I  = 2'd1,
        SERV_D  = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_t;

    // A simultaneous read+write from the dcache resolves to a write.
    function automatic op_t dcache_op(input logic rd, input logic wr);
        if (wr) return OP_WRITE;
        if (rd) return OP_READ;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/mem_arbiter_ctrl.sv
// Arbiter control: IDLE/SERV_I/SERV_D/RECOVER FSM, dcache streak counter and grant decision.
module mem_arbiter_ctrl
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic icache_read,
    input  logic dcache_read,
    input  logic dcache_write,
    input  logic pmem_resp,
    output logic grant_i,
    output logic grant_d,
    output logic serv_i,
    output logic serv_d,
    output logic pmem_read,
    output logic pmem_write
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_t          state_q, state_d;
    op_t                 op_q, op_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic d_req;
    assign d_req = dcache_read | dcache_write;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        streak_d = streak_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (icache_read && streak_q == STREAK_MAX) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end else if (icache_read) begin
                    grant_i = 1'b1;
                end

                if (grant_i) begin
                    state_d  = SERV_I;
                    op_d     = OP_READ;
                    streak_d = '0;
                end else if (grant_d) begin
                    state_d  = SERV_D;
                    op_d     = dcache_op(dcache_read, dcache_write);
                    // Only count dcache wins that actually made the icache wait.
                    if (!icache_read) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end
            end

            SERV_I, SERV_D: begin
                if (pmem_resp) begin
                    state_d = RECOVER;
                    op_d    = OP_NONE;
                end
            end

            RECOVER: state_d = IDLE;

            default: begin
                state_d = IDLE;
                op_d    = OP_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_NONE;
            streak_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            streak_q <= streak_d;
        end
    end

    // op_q is OP_NONE outside SERV_x, so strobes decode straight from a register.
    assign pmem_read  = (op_q == OP_READ);
    assign pmem_write = (op_q == OP_WRITE);
    assign serv_i     = (state_q == SERV_I);
    assign serv_d     = (state_q == SERV_D);

    a_no_dcache_rw: assert property (@(posedge clk) disable iff (!rst_n)
        !(dcache_read && dcache_write));

endmodule

// File: rtl/mem_arbiter.sv
// Top level: shares one physical-memory port between icache and dcache, latching the
// winner's address/data and routing the memory response back to the owner only.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 256,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    logic grant_i, grant_d, serv_i, serv_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    mem_arbiter_ctrl #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .icache_read  (icache_read),
        .dcache_read  (dcache_read),
        .dcache_write (dcache_write),
        .pmem_resp    (pmem_resp),
        .grant_i      (grant_i),
        .grant_d      (grant_d),
        .serv_i       (serv_i),
        .serv_d       (serv_d),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write)
    );

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (grant_i) begin
            addr_d = icache_address;
        end else if (grant_d) begin
            addr_d = dcache_address;
            if (dcache_write) begin
                wdata_d = dcache_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these wide data registers are reset because the memory port has defined reset values.
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Data fans out to both caches; only the owner's resp qualifies it.
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;
    assign icache_resp  = serv_i & pmem_resp;
    assign dcache_resp  = serv_d & pmem_resp;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int MAX_D  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W),
        .MAX_D_STREAK(MAX_D)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    typedef struct {
        bit          timeout;
        int          latency;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [255:0] wdata;
        bit          held;
        logic        ires;
        logic        dres;
        logic [255:0] rdata;
        logic [255:0] ird;
        logic [255:0] drd;
        bit          rec_low;
    } txn_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Memory responder: waits (bounded) for a strobe, records it, answers after
    // `delay` cycles, records the routed response, and returns one cycle later.
    task automatic mem_txn(input int delay, output txn_t t);
        t = '{default: 0};
        while (!(pmem_read === 1'b1 || pmem_write === 1'b1) && t.latency < 30) begin
            tick();
            t.latency++;
        end
        if (!(pmem_read === 1'b1 || pmem_write === 1'b1)) begin
            t.timeout = 1;
        end else begin
            t.rd    = pmem_read;
            t.wr    = pmem_write;
            t.addr  = pmem_address;
            t.wdata = pmem_wdata;
            t.held  = 1;
            for (int i = 0; i < delay; i++) begin
                tick();
                if (pmem_read !== t.rd || pmem_write !== t.wr) t.held = 0;
            end
            t.rdata    = rand_line();
            pmem_rdata = t.rdata;
            pmem_resp  = 1'b1;
            #1;
            t.ires = icache_resp;
            t.dres = dcache_resp;
            t.ird  = icache_rdata;
            t.drd  = dcache_rdata;
            tick();
            pmem_resp = 1'b0;
            t.rec_low = (pmem_read === 1'b0 && pmem_write === 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        icache_read = 0; icache_address = '0;
        dcache_read = 0; dcache_write = 0; dcache_address = '0; dcache_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            errors++; $display("FAIL reset_strobes: got %b want 00", {pmem_read, pmem_write});
        end
        checks++;
        if (pmem_address !== '0 || pmem_wdata !== '0) begin
            errors++; $display("FAIL reset_latches: got addr %0h wdata %0h want 0", pmem_address, pmem_wdata);
        end
        checks++;
        if ({icache_resp, dcache_resp} !== 2'b00) begin
            errors++; $display("FAIL reset_resp: got %b want 00", {icache_resp, dcache_resp});
        end
        pmem_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0000) begin
                errors++; $display("FAIL idle_quiet: cycle %0d got %b want 0000", i,
                                   {pmem_read, pmem_write, icache_resp, dcache_resp});
            end
            tick();
        end
    endtask

    task automatic test_icache_basic();
        logic [255:0] rd;
        icache_read = 1'b1;
        icache_address = 32'h100;
        checks++;
        if (pmem_read !== 1'b0) begin
            errors++; $display("FAIL ib_pre_edge: got %b want 0", pmem_read);
        end
        tick();
        checks++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin
            errors++; $display("FAIL ib_strobe: got rd %b wr %b want rd 1 wr 0", pmem_read, pmem_write);
        end
        checks++;
        if (pmem_address !== 32'h100) begin
            errors++; $display("FAIL ib_addr: got %0h want 100", pmem_address);
        end
        tick();
        tick();
        checks++;
        if (pmem_read !== 1'b1) begin
            errors++; $display("FAIL ib_hold: got %b want 1", pmem_read);
        end
        rd = rand_line();
        pmem_rdata = rd;
        pmem_resp = 1'b1;
        #1;
        checks++;
        if ({icache_resp, dcache_resp} !== 2'b10) begin
            errors++; $display("FAIL ib_resp: got i/d %b want 10", {icache_resp, dcache_resp});
        end
        checks++;
        if (icache_rdata !== rd) begin
            errors++; $display("FAIL ib_rdata: got %0h want %0h", icache_rdata, rd);
        end
        tick();
        pmem_resp = 1'b0;
        icache_read = 1'b0;
        checks++;
        if ({pmem_read, icache_resp} !== 2'b00) begin
            errors++; $display("FAIL ib_recover: got rd/resp %b want 00", {pmem_read, icache_resp});
        end
        tick();
        tick();
        checks++;
        if (pmem_read !== 1'b0) begin
            errors++; $display("FAIL ib_no_regrant: got %b want 0", pmem_read);
        end
    endtask

    task automatic test_write_then_read();
        txn_t t;
        logic [31:0]  da = 32'hD000_0040;
        logic [31:0]  ia = 32'h0000_2200;
        logic [255:0] wd = rand_line();
        dcache_write = 1'b1; dcache_address = da; dcache_wdata = wd;
        icache_read = 1'b1;  icache_address = ia;
        mem_txn(1, t);
        checks++;
        if (t.timeout || {t.rd, t.wr} !== 2'b01 || t.addr !== da) begin
            errors++; $display("FAIL wr_first: got to %0d rd %b wr %b addr %0h want wr addr %0h",
                               t.timeout, t.rd, t.wr, t.addr, da);
        end
        checks++;
        if (t.wdata !== wd) begin
            errors++; $display("FAIL wr_wdata: got %0h want %0h", t.wdata, wd);
        end
        checks++;
        if ({t.ires, t.dres} !== 2'b01 || !t.rec_low) begin
            errors++; $display("FAIL wr_resp: got i/d %b rec_low %0d want 01 1", {t.ires, t.dres}, t.rec_low);
        end
        dcache_write = 1'b0;
        mem_txn(0, t);
        checks++;
        if (t.timeout || {t.rd, t.wr} !== 2'b10 || t.addr !== ia) begin
            errors++; $display("FAIL rd_second: got to %0d rd %b wr %b addr %0h want rd addr %0h",
                               t.timeout, t.rd, t.wr, t.addr, ia);
        end
        checks++;
        if ({t.ires, t.dres} !== 2'b10 || t.ird !== t.rdata) begin
            errors++; $display("FAIL rd_resp: got i/d %b rdata %0h want 10 %0h", {t.ires, t.dres}, t.ird, t.rdata);
        end
        checks++;
        if (t.latency !== 2) begin
            errors++; $display("FAIL recover_bubble: got %0d cycles want 2", t.latency);
        end
        icache_read = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        txn_t t;
        logic [31:0] da;
        icache_read = 1'b1; icache_address = 32'h0000_4440;
        da = $urandom;
        dcache_read = 1'b1; dcache_address = da;
        for (int k = 0; k < 6; k++) begin
            bit exp_i = (k == MAX_D);
            mem_txn($urandom_range(0, 2), t);
            checks++;
            if (t.timeout || {t.ires, t.dres} !== {exp_i, !exp_i}) begin
                errors++; $display("FAIL starve_owner: grant %0d got to %0d i/d %b want %b",
                                   k, t.timeout, {t.ires, t.dres}, {exp_i, !exp_i});
            end
            checks++;
            if (t.addr !== (exp_i ? 32'h0000_4440 : da)) begin
                errors++; $display("FAIL starve_addr: grant %0d got %0h want %0h",
                                   k, t.addr, exp_i ? 32'h0000_4440 : da);
            end
            if (exp_i) icache_read = 1'b0;
            else begin
                da = $urandom;
                dcache_address = da;
            end
        end
        dcache_read = 1'b0;
        icache_read = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        dcache_write = 1'b1; dcache_address = 32'hABCD_0000; dcache_wdata = rand_line();
        while (pmem_write !== 1'b1 && n < 10) begin tick(); n++; end
        checks++;
        if (pmem_write !== 1'b1) begin
            errors++; $display("FAIL rm_start: got %b want 1", pmem_write);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            errors++; $display("FAIL rm_async_drop: got %b want 00", {pmem_read, pmem_write});
        end
        checks++;
        if (pmem_address !== '0 || pmem_wdata !== '0) begin
            errors++; $display("FAIL rm_latches: got addr %0h wdata %0h want 0", pmem_address, pmem_wdata);
        end
        dcache_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            pmem_resp = 1'b1;
            #1;
            checks++;
            if ({icache_resp, dcache_resp, pmem_read, pmem_write} !== 4'b0000) begin
                errors++; $display("FAIL rm_no_resp: cycle %0d got %b want 0000", i,
                                   {icache_resp, dcache_resp, pmem_read, pmem_write});
            end
            tick();
        end
        pmem_resp = 1'b0;
    endtask

    task automatic test_spurious_and_drop();
        int n = 0;
        logic [255:0] rd;
        pmem_resp = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({icache_resp, dcache_resp} !== 2'b00) begin
                errors++; $display("FAIL sp_idle_resp: got %b want 00", {icache_resp, dcache_resp});
            end
            tick();
        end
        pmem_resp = 1'b0;
        dcache_read = 1'b1; dcache_address = 32'h0000_7780;
        while (pmem_read !== 1'b1 && n < 10) begin tick(); n++; end
        dcache_read = 1'b0;
        tick();
        tick();
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_7780) begin
            errors++; $display("FAIL drop_hold: got rd %b addr %0h want 1 7780", pmem_read, pmem_address);
        end
        rd = rand_line();
        pmem_rdata = rd;
        pmem_resp = 1'b1;
        #1;
        checks++;
        if ({icache_resp, dcache_resp} !== 2'b01 || dcache_rdata !== rd) begin
            errors++; $display("FAIL drop_resp: got i/d %b rdata %0h want 01 %0h",
                               {icache_resp, dcache_resp}, dcache_rdata, rd);
        end
        tick();
        checks++;
        if ({dcache_resp, pmem_read} !== 2'b00) begin
            errors++; $display("FAIL sp_recover_resp: got resp/rd %b want 00", {dcache_resp, pmem_read});
        end
        tick();
        checks++;
        if ({icache_resp, dcache_resp, pmem_read} !== 3'b000) begin
            errors++; $display("FAIL sp_after_resp: got %b want 000", {icache_resp, dcache_resp, pmem_read});
        end
        pmem_resp = 1'b0;
        tick();
    endtask

    // Transaction-level model: pending requests, who wins the next grant, streak count.
    task automatic test_random();
        txn_t t;
        bit ipend = 0, dpend = 0, dwr = 0, exp_i;
        int s = 0;
        logic [31:0] ia = '0, da = '0;
        logic [255:0] dwd = '0;
        for (int k = 0; k < 40; k++) begin
            if (!ipend && $urandom_range(0, 1) == 1) begin
                ipend = 1; ia = $urandom;
            end
            if (!dpend && $urandom_range(0, 3) != 0) begin
                dpend = 1; da = $urandom; dwr = $urandom_range(0, 1) == 1; dwd = rand_line();
            end
            if (!ipend && !dpend) begin
                ipend = 1; ia = $urandom;
            end
            icache_read = ipend; icache_address = ia;
            dcache_read = dpend && !dwr; dcache_write = dpend && dwr;
            dcache_address = da; dcache_wdata = dwd;

            exp_i = (ipend && s == MAX_D) || (ipend && !dpend);
            if (exp_i) s = 0;
            else s = ipend ? ((s < MAX_D) ? s + 1 : MAX_D) : 0;

            mem_txn($urandom_range(0, 3), t);
            checks++;
            if (t.timeout || {t.ires, t.dres} !== {exp_i, !exp_i}) begin
                errors++; $display("FAIL rnd_owner: txn %0d got to %0d i/d %b want %b",
                                   k, t.timeout, {t.ires, t.dres}, {exp_i, !exp_i});
            end
            checks++;
            if ({t.rd, t.wr} !== (exp_i ? 2'b10 : (dwr ? 2'b01 : 2'b10))) begin
                errors++; $display("FAIL rnd_op: txn %0d got rd %b wr %b", k, t.rd, t.wr);
            end
            checks++;
            if (t.addr !== (exp_i ? ia : da)) begin
                errors++; $display("FAIL rnd_addr: txn %0d got %0h want %0h", k, t.addr, exp_i ? ia : da);
            end
            if (!exp_i && dwr) begin
                checks++;
                if (t.wdata !== dwd) begin
                    errors++; $display("FAIL rnd_wdata: txn %0d got %0h want %0h", k, t.wdata, dwd);
                end
            end
            checks++;
            if ((exp_i ? t.ird : t.drd) !== t.rdata) begin
                errors++; $display("FAIL rnd_rdata: txn %0d got %0h want %0h",
                                   k, exp_i ? t.ird : t.drd, t.rdata);
            end
            checks++;
            if (!t.held || !t.rec_low) begin
                errors++; $display("FAIL rnd_strobe: txn %0d got held %0d rec_low %0d want 1 1",
                                   k, t.held, t.rec_low);
            end
            if (exp_i) ipend = 0;
            else dpend = 0;
            icache_read = ipend;
            dcache_read = dpend && !dwr;
            dcache_write = dpend && dwr;
        end
        icache_read = 0; dcache_read = 0; dcache_write = 0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle();
        test_icache_basic();
        test_write_then_read();
        test_starvation();
        test_reset_mid();
        test_spurious_and_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache (read-only) and the data cache (read/write).
- Grants one requester per transaction, latches that requester's command and address, drives the memory port, and routes the memory response back to the owner only.
- Uses fixed dcache priority with a bounded-starvation counter so icache fetches cannot be locked out by streams of back-to-back dcache misses.

Parameters:
- ADDR_W, 32, address width for both caches and memory.
- LINE_W, 256, cache-line data width.
- MAX_D_STREAK, 4, consecutive dcache grants allowed while icache waits; must be ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- icache_read  in  1  icache line-fill request, held until icache_resp
- icache_address  in  ADDR_W  icache line address
- icache_rdata  out  LINE_W  fill data
- icache_resp  out  1  one-cycle completion pulse to icache
- dcache_read  in  1  dcache fill request, held until dcache_resp
- dcache_write  in  1  dcache writeback request, held until dcache_resp
- dcache_address  in  ADDR_W  dcache line address
- dcache_wdata  in  LINE_W  writeback data
- dcache_rdata  out  LINE_W  fill data
- dcache_resp  out  1  one-cycle completion pulse to dcache
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_W  latched transaction address
- pmem_wdata  out  LINE_W  latched write data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory completion pulse

Behaviour:
- States: IDLE, SERV_I, SERV_D, RECOVER. Reset state is IDLE.
- Reset values: pmem_read, pmem_write, icache_resp and dcache_resp are 0; pmem_address and pmem_wdata are 0; streak counter is 0. Reset clears these asynchronously, including mid-transaction, and strobes drop immediately.
- IDLE arbitration, evaluated each cycle:
  - icache wins if icache_read && streak == MAX_D_STREAK.
  - Otherwise dcache wins if dcache_read || dcache_write.
  - Otherwise icache wins if icache_read.
  - The winner's address and operation are latched (and dcache_wdata for a write) at the clock edge that enters SERV_x.
- dcache_read && dcache_write together: write wins. This is a protocol error; the arbiter flags it with a simulation assertion only.
- Latency: a request sampled in IDLE at edge N gives the pmem strobe high from N+1. The strobe is registered from state plus latched op, and pmem_address/pmem_wdata are valid in the same cycle.
- SERV_x: strobes are held until pmem_resp.
  - In the pmem_resp cycle, the owner's resp equals pmem_resp combinationally, and the owner's rdata equals pmem_rdata.
  - The non-owner's resp stays 0.
  - Both rdata outputs may pass pmem_rdata through; only resp qualifies them.
  - The next state after pmem_resp is RECOVER.
- RECOVER: one cycle with strobes low, so the owner can drop its request. Then IDLE. No back-to-back grants without this bubble.
- Requester deasserts its request mid-grant (violation): the transaction still completes and resp still pulses to the latched owner.
- pmem_resp in IDLE or RECOVER is ignored and never forwarded.
- Streak counter, width $clog2(MAX_D_STREAK+1), saturating:
  - On a dcache grant with icache_read high, increment.
  - On a dcache grant with icache_read low, clear.
  - On an icache grant, clear.
- An idle memory port with no requests stays in IDLE with all strobes 0.

Decomposition:
- Shared package holds the state enum (arb_state_t) and an op enum (OP_NONE/OP_READ/OP_WRITE).
- One natural sub-module: mem_arbiter_ctrl, containing the FSM, streak counter and grant decision.
- The top level holds the address/wdata latches and response/data routing.

Test Plan:
- Reset then icache_read=1, address 0x100, with pmem_resp two cycles after the strobe:
  - pmem_read rises one cycle after the request, pmem_address = 0x100.
  - icache_resp pulses with pmem_resp; dcache_resp stays 0.
- dcache_write and icache_read asserted in the same cycle:
  - dcache is served first, with pmem_write=1 and pmem_wdata = dcache_wdata.
  - After RECOVER, icache is served with pmem_read=1.
- dcache requests continuously with icache_read held, MAX_D_STREAK=4:
  - Exactly 4 dcache grants occur, then an icache grant, then dcache resumes.
- Reset asserted while in SERV_D with pmem_write high:
  - pmem_write drops in the same cycle with no clock edge needed, and state is IDLE.
  - No resp is delivered after reset deasserts.
- Spurious pmem_resp in IDLE, and dcache_read dropped mid-grant:
  - No resp in IDLE.
  - The mid-grant transaction still completes with a dcache_resp pulse.
